// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int DEFAULT_CLK_PER_BIT = 868;
  localparam int UART_DATA_BITS      = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter; push is ignored when full, pop when empty,
// and the head entry is visible on data_o without a read latency.
module uart_tx_fifo #(
  parameter int FIFO_WIDTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  pop_i,
  output logic [DATA_W-1:0]     data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [FIFO_WIDTH:0]   count_o
);

  localparam int                DEPTH      = 1 << FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0] FULL_COUNT = (FIFO_WIDTH + 1)'(DEPTH);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_WIDTH:0]   count_q, count_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_WIDTH'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + FIFO_WIDTH'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (FIFO_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count guards every read, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// UART transmit path: buffers bytes from decode and sends them 8N1, LSB first, on txd,
// stalling decode while the buffer is full.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int FIFO_WIDTH  = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       RegtoUART,
  input  logic [7:0] tx_data,
  output logic       stall,
  output logic       busy,
  output logic       txd
);

  localparam int                BAUD_W    = $clog2(CLK_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);

  uart_state_t         state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                txd_q, txd_d;
  logic                pop;
  logic                baud_end;
  logic [7:0]          fifo_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FIFO_WIDTH:0] fifo_count;

  uart_tx_fifo #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .DATA_W     (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (RegtoUART),
    .data_i  (tx_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign stall    = fifo_full;
  assign busy     = (fifo_count != '0) || (state_q != IDLE);
  assign txd      = txd_q;
  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        baud_d  = '0;
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

endmodule
